// File: rtl/counter_evt_pkg.sv
// Shared event definitions for the counter event logger.
// Bit positions of each event within the flag vectors and the entry-width helper.
package counter_evt_pkg;

    localparam int unsigned NUM_EVT = 3;

    typedef enum logic [1:0] {
        OVF  = 2'd0,
        UNF  = 2'd1,
        TERM = 2'd2
    } evt_bit_e;

    function automatic int unsigned entry_width(input int unsigned count_w, input int unsigned ts_w);
        return NUM_EVT + count_w + ts_w;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Generic first-word-fall-through synchronous FIFO with an explicit level counter.
// A push while full is only accepted when a pop frees a slot on the same edge.
module evt_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/counter_event_logger.sv
// Captures rising edges of enabled counter events with count and timestamp into a FIFO,
// tracks dropped events and raises irq on fill threshold or loss.
module counter_event_logger
    import counter_evt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     overflow,
    input  logic                     underflow,
    input  logic                     terminal_flag,
    input  logic [WIDTH-1:0]         count,
    input  logic [2:0]               event_mask,
    input  logic [$clog2(DEPTH):0]   irq_threshold,
    input  logic                     irq_clear,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [2:0]               evt_flags,
    output logic [WIDTH-1:0]         evt_count,
    output logic [TS_WIDTH-1:0]      evt_timestamp,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               dropped_count,
    output logic                     lost,
    output logic                     irq
);

    localparam int unsigned EW = entry_width(WIDTH, TS_WIDTH);

    // Entry layout depends on the module widths, so the struct lives here rather than in the package.
    typedef struct packed {
        logic [NUM_EVT-1:0]  flags;
        logic [WIDTH-1:0]    count;
        logic [TS_WIDTH-1:0] timestamp;
    } evt_entry_t;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [NUM_EVT-1:0]  prev_q, prev_d;
    logic [7:0]          dropped_q, dropped_d;
    logic                lost_q, lost_d;
    logic                irq_q, irq_d;

    logic [NUM_EVT-1:0]  raw_evt;
    logic [NUM_EVT-1:0]  hit;
    logic                push;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    evt_entry_t          wr_entry;
    evt_entry_t          head;

    always_comb begin
        raw_evt       = '0;
        raw_evt[OVF]  = overflow;
        raw_evt[UNF]  = underflow;
        raw_evt[TERM] = terminal_flag;
    end

    assign hit  = raw_evt & ~prev_q & event_mask;
    assign push = |hit;
    assign pop  = evt_valid & evt_ready;
    assign drop = push & fifo_full & ~pop;

    always_comb begin
        wr_entry           = '0;
        wr_entry.flags     = hit;
        wr_entry.count     = count;
        wr_entry.timestamp = ts_q;
    end

    evt_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A drop on the same edge as irq_clear wins: the counter restarts at one.
    always_comb begin
        ts_d      = ts_q + TS_WIDTH'(1);
        prev_d    = raw_evt;
        dropped_d = dropped_q;
        lost_d    = lost_q;
        if (irq_clear) begin
            dropped_d = '0;
            lost_d    = 1'b0;
        end
        if (drop) begin
            lost_d    = 1'b1;
            dropped_d = irq_clear ? 8'd1 : ((dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1);
        end
        irq_d = ((irq_threshold != '0) && (fifo_level >= irq_threshold)) || lost_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q      <= '0;
            prev_q    <= '0;
            dropped_q <= '0;
            lost_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ts_q      <= ts_d;
            prev_q    <= prev_d;
            dropped_q <= dropped_d;
            lost_q    <= lost_d;
            irq_q     <= irq_d;
        end
    end

    assign evt_valid     = ~fifo_empty;
    assign evt_flags     = head.flags;
    assign evt_count     = head.count;
    assign evt_timestamp = head.timestamp;
    assign dropped_count = dropped_q;
    assign lost          = lost_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed bench for counter_event_logger with a queue-based reference model checked every cycle.
module tb_counter_event_logger;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned TS_WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   overflow = 1'b0;
    logic                   underflow = 1'b0;
    logic                   terminal_flag = 1'b0;
    logic [WIDTH-1:0]       count = '0;
    logic [2:0]             event_mask = 3'b111;
    logic [3:0]             irq_threshold = '0;
    logic                   irq_clear = 1'b0;
    logic                   evt_ready = 1'b0;
    logic                   evt_valid;
    logic [2:0]             evt_flags;
    logic [WIDTH-1:0]       evt_count;
    logic [TS_WIDTH-1:0]    evt_timestamp;
    logic [3:0]             fifo_level;
    logic [7:0]             dropped_count;
    logic                   lost;
    logic                   irq;

    int errors = 0;
    int checks = 0;

    counter_event_logger #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .TS_WIDTH (TS_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .overflow      (overflow),
        .underflow     (underflow),
        .terminal_flag (terminal_flag),
        .count         (count),
        .event_mask    (event_mask),
        .irq_threshold (irq_threshold),
        .irq_clear     (irq_clear),
        .evt_ready     (evt_ready),
        .evt_valid     (evt_valid),
        .evt_flags     (evt_flags),
        .evt_count     (evt_count),
        .evt_timestamp (evt_timestamp),
        .fifo_level    (fifo_level),
        .dropped_count (dropped_count),
        .lost          (lost),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]          f;
        logic [WIDTH-1:0]    c;
        logic [TS_WIDTH-1:0] t;
    } ent_t;

    ent_t                q[$];
    logic [TS_WIDTH-1:0] mts;
    logic [2:0]          mprev;
    int                  mdropped;
    logic                mlost;
    logic                mirq;

    // Reference model: a queue of entries plus plain counters.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            mts = '0; mprev = '0; mdropped = 0; mlost = 1'b0; mirq = 1'b0;
        end else begin
            logic [2:0] ev;
            logic [2:0] hit;
            bit         popped;
            bit         dropped;
            ev      = {terminal_flag, underflow, overflow};
            hit     = ev & ~mprev & event_mask;
            mirq    = ((irq_threshold != 0) && (q.size() >= int'(irq_threshold))) || mlost;
            popped  = (q.size() > 0) && evt_ready;
            dropped = 1'b0;
            if (hit != 0 && q.size() == DEPTH && !popped) dropped = 1'b1;
            if (popped) void'(q.pop_front());
            if (hit != 0 && !dropped) q.push_back('{f: hit, c: count, t: mts});
            if (irq_clear) begin
                mdropped = 0;
                mlost    = 1'b0;
            end
            if (dropped) begin
                mlost    = 1'b1;
                mdropped = (mdropped < 255) ? mdropped + 1 : 255;
            end
            mprev = ev;
            mts   = mts + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", 32'(evt_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("flags", 32'(evt_flags), 32'(q[0].f));
                chk("count", 32'(evt_count), 32'(q[0].c));
                chk("timestamp", 32'(evt_timestamp), 32'(q[0].t));
            end
            chk("level", 32'(fifo_level), 32'(q.size()));
            chk("dropped", 32'(dropped_count), 32'(mdropped));
            chk("lost", 32'(lost), 32'(mlost));
            chk("irq", 32'(irq), 32'(mirq));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    logic [TS_WIDTH-1:0] old_ts;

    initial begin
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_flags", 32'(evt_flags), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_ts", 32'(evt_timestamp), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_dropped", 32'(dropped_count), 32'd0);
        chk("rst_lost", 32'(lost), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        cyc(2);
        rst = 1'b0;

        // Overflow captured at ts=5 with count 15
        cyc(5);
        overflow = 1'b1; count = 4'hF;
        cyc();
        overflow = 1'b0;
        chk("t1_valid", 32'(evt_valid), 32'd1);
        chk("t1_flags", 32'(evt_flags), 32'h1);
        chk("t1_count", 32'(evt_count), 32'd15);
        chk("t1_ts", 32'(evt_timestamp), 32'd5);
        chk("t1_level", 32'(fifo_level), 32'd1);
        evt_ready = 1'b1;
        cyc();
        evt_ready = 1'b0;

        // Simultaneous overflow + terminal share one entry
        overflow = 1'b1; terminal_flag = 1'b1; count = 4'hA; evt_ready = 1'b1;
        cyc();
        overflow = 1'b0; terminal_flag = 1'b0;
        chk("t2_flags", 32'(evt_flags), 32'h5);
        chk("t2_count", 32'(evt_count), 32'd10);
        chk("t2_level", 32'(fifo_level), 32'd1);
        cyc();
        chk("t2_level_after", 32'(fifo_level), 32'd0);
        evt_ready = 1'b0;

        // Only underflow enabled
        event_mask = 3'b010; count = 4'h3;
        overflow = 1'b1;      cyc(); overflow = 1'b0;      cyc();
        underflow = 1'b1;     cyc(); underflow = 1'b0;     cyc();
        terminal_flag = 1'b1; cyc(); terminal_flag = 1'b0; cyc();
        chk("t3_level", 32'(fifo_level), 32'd1);
        chk("t3_flags", 32'(evt_flags), 32'h2);
        evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
        chk("t3_empty", 32'(evt_valid), 32'd0);

        // Overfill: 11 underflow pulses into 8 entries
        event_mask = 3'b111; irq_threshold = 4'd8;
        for (int i = 0; i < 11; i++) begin
            underflow = 1'b1; count = 4'(i); cyc();
            underflow = 1'b0; cyc();
        end
        chk("t4_level", 32'(fifo_level), 32'd8);
        chk("t4_dropped", 32'(dropped_count), 32'd3);
        chk("t4_lost", 32'(lost), 32'd1);
        chk("t4_irq", 32'(irq), 32'd1);
        irq_clear = 1'b1; cyc(); irq_clear = 1'b0;
        chk("t4_clr_lost", 32'(lost), 32'd0);
        chk("t4_clr_dropped", 32'(dropped_count), 32'd0);
        cyc();
        chk("t4_irq_level", 32'(irq), 32'd1);
        irq_threshold = 4'd9; cyc();
        chk("t4_irq_below", 32'(irq), 32'd0);
        irq_threshold = 4'd8;

        // Full with push and pop on the same edge
        old_ts = evt_timestamp;
        underflow = 1'b1; evt_ready = 1'b1; cyc();
        underflow = 1'b0; evt_ready = 1'b0;
        chk("t5_level", 32'(fifo_level), 32'd8);
        chk("t5_dropped", 32'(dropped_count), 32'd0);
        chk("t5_head_ts", 32'(evt_timestamp), 32'(old_ts + 16'd2));
        cyc();

        // Reset with entries queued
        evt_ready = 1'b1; cyc(3); evt_ready = 1'b0;
        chk("t6_level_pre", 32'(fifo_level), 32'd5);
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(evt_valid), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_irq", 32'(irq), 32'd0);
        cyc();
        rst = 1'b0; overflow = 1'b1; count = 4'h7;
        cyc();
        overflow = 1'b0;
        chk("t6_ts0", 32'(evt_timestamp), 32'd0);
        chk("t6_flags", 32'(evt_flags), 32'h1);
        chk("t6_count", 32'(evt_count), 32'd7);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
